// File: rtl/tdm_pkg.sv
// Shared definitions for the 16-channel TDM link: FSM states and the channel
// index width that both the transmit mux and the receive demux must agree on.
package tdm_pkg;

    localparam int CHANNELS = 16;
    localparam int SEL_W    = 4;

    // Index of the final beat of a frame.
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(CHANNELS - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } tdm_state_e;

    // Packs the sixteen individual channel pins into one word, channel 0 at bit 0.
    function automatic logic [CHANNELS-1:0] pack_channels(
        input logic d0,  input logic d1,  input logic d2,  input logic d3,
        input logic d4,  input logic d5,  input logic d6,  input logic d7,
        input logic d8,  input logic d9,  input logic d10, input logic d11,
        input logic d12, input logic d13, input logic d14, input logic d15
    );
        return {d15, d14, d13, d12, d11, d10, d9, d8,
                d7,  d6,  d5,  d4,  d3,  d2,  d1, d0};
    endfunction

endpackage

// File: rtl/tdm_mux_16to1_mux.sv
// Combinational 16:1 bit selector; the transmit-side mirror of the demux stage.
module mux_16to1
    import tdm_pkg::*;
(
    input  logic [CHANNELS-1:0] din,
    input  logic [SEL_W-1:0]    sel,
    output logic                data
);

    assign data = din[sel];

endmodule

// File: rtl/tdm_mux_16to1.sv
// Sequential 16:1 time-division multiplexer: snapshots d0..d15 on start and
// streams them one bit per accepted beat with the channel index on sel.
//
// Handshake: a beat is held on data/sel/sof/eof with out_valid high until the
// consumer accepts it (out_valid && out_ready at a rising edge); out_valid
// never drops and the beat never changes before acceptance.
module tdm_mux_16to1
    import tdm_pkg::*;
#(
    parameter bit CONTINUOUS = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             d0,
    input  logic             d1,
    input  logic             d2,
    input  logic             d3,
    input  logic             d4,
    input  logic             d5,
    input  logic             d6,
    input  logic             d7,
    input  logic             d8,
    input  logic             d9,
    input  logic             d10,
    input  logic             d11,
    input  logic             d12,
    input  logic             d13,
    input  logic             d14,
    input  logic             d15,
    input  logic             start,
    output logic             data,
    output logic [SEL_W-1:0] sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sof,
    output logic             eof,
    output logic             busy,
    output logic             done,
    output tdm_state_e       dbg_state
);

    logic [CHANNELS-1:0] d_vec;

    tdm_state_e          state_q, state_d;
    logic [CHANNELS-1:0] snap_q,  snap_d;
    logic [SEL_W-1:0]    cnt_q,   cnt_d;
    logic                sof_q,   sof_d;
    logic                eof_q,   eof_d;
    logic                done_q,  done_d;

    logic                accept;
    logic                final_accept;
    logic                recapture;

    assign d_vec = pack_channels(d0, d1, d2, d3, d4, d5, d6, d7,
                                 d8, d9, d10, d11, d12, d13, d14, d15);

    assign accept       = (state_q == SHIFT) && out_ready;
    assign final_accept = accept && (cnt_q == LAST_SEL);
    assign recapture    = start || CONTINUOUS;

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    snap_d  = d_vec;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (final_accept) begin
                    done_d = 1'b1;
                    cnt_d  = '0;
                    // Back-to-back frames reload without a bubble beat.
                    if (recapture) begin
                        snap_d = d_vec;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Frame markers are registered from the next-cycle index so they line up
    // with the beat they describe.
    always_comb begin
        sof_d = (state_d == SHIFT) && (cnt_d == '0);
        eof_d = (state_d == SHIFT) && (cnt_d == LAST_SEL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            snap_q  <= '0;
            cnt_q   <= '0;
            sof_q   <= 1'b0;
            eof_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            cnt_q   <= cnt_d;
            sof_q   <= sof_d;
            eof_q   <= eof_d;
            done_q  <= done_d;
        end
    end

    mux_16to1 u_mux (
        .din  (snap_q),
        .sel  (cnt_q),
        .data (data)
    );

    assign sel       = cnt_q;
    assign out_valid = (state_q == SHIFT);
    assign busy      = (state_q == SHIFT);
    assign sof       = sof_q;
    assign eof       = eof_q;
    assign done      = done_q;
    assign dbg_state = state_q;

endmodule
